// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encoding, stage constants and counter sizing for the game sequencer
package game_pkg;

    typedef enum logic [3:0] {
        TITLE_DRAW,
        TITLE_WAIT,
        BEGIN_DRAW,
        BEGIN_HOLD,
        PLAY,
        CLEAR_DRAW,
        CLEAR_HOLD,
        WIN_DRAW,
        LOSE_DRAW,
        END_WAIT,
        REARM
    } state_t;

    localparam logic [1:0] STAGE_LAST = 2'd3;

    // One counter serves both the hold and the watchdog, so size it for the larger.
    function automatic int cnt_w(input int hold_cycles, input int timeout_cycles);
        return $clog2(((hold_cycles > timeout_cycles) ? hold_cycles : timeout_cycles) + 1);
    endfunction

    function automatic logic is_draw(input state_t s);
        return (s == TITLE_DRAW) || (s == BEGIN_DRAW) || (s == CLEAR_DRAW) ||
               (s == WIN_DRAW)   || (s == LOSE_DRAW);
    endfunction

    function automatic logic is_hold(input state_t s);
        return (s == BEGIN_HOLD) || (s == CLEAR_HOLD);
    endfunction

    // Stage 1..3 to a one-hot request select; stage 0 selects nothing.
    function automatic logic [2:0] stage_onehot(input logic [1:0] stage);
        logic [2:0] v;
        v = 3'b000;
        case (stage)
            2'd1:    v = 3'b001;
            2'd2:    v = 3'b010;
            2'd3:    v = 3'b100;
            default: v = 3'b000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/game_flow_controller_if.sv
// rtl/game_flow_controller_if.sv - screen request / draw-done handshake bundle between sequencer and display side
// master: the sequencer (drives requests, play_enable, current_stage, draw_resetn, draw_timeout)
// slave : gameplay + draw modules (drive start_key, stage_clear, player_dead and all *_done)
interface game_flow_controller_if;
    logic       start_key;
    logic       stage_clear;
    logic       player_dead;
    logic       SAVE_GPA_done;
    logic       stage_1_begin_done;
    logic       stage_2_begin_done;
    logic       stage_3_begin_done;
    logic       stage_1_end_display_done;
    logic       stage_2_end_display_done;
    logic       stage_3_end_display_done;
    logic       WIN_done;
    logic       LOSE_done;
    logic       wait_start;
    logic       stage_1_begin;
    logic       stage_1_done;
    logic       stage_2_begin;
    logic       stage_2_done;
    logic       stage_3_begin;
    logic       stage_3_done;
    logic       win;
    logic       game_over;
    logic       play_enable;
    logic [1:0] current_stage;
    logic       draw_resetn;
    logic       draw_timeout;

    modport master (
        input  start_key, stage_clear, player_dead, SAVE_GPA_done,
               stage_1_begin_done, stage_2_begin_done, stage_3_begin_done,
               stage_1_end_display_done, stage_2_end_display_done, stage_3_end_display_done,
               WIN_done, LOSE_done,
        output wait_start, stage_1_begin, stage_1_done, stage_2_begin, stage_2_done,
               stage_3_begin, stage_3_done, win, game_over,
               play_enable, current_stage, draw_resetn, draw_timeout
    );

    modport slave (
        output start_key, stage_clear, player_dead, SAVE_GPA_done,
               stage_1_begin_done, stage_2_begin_done, stage_3_begin_done,
               stage_1_end_display_done, stage_2_end_display_done, stage_3_end_display_done,
               WIN_done, LOSE_done,
        input  wait_start, stage_1_begin, stage_1_done, stage_2_begin, stage_2_done,
               stage_3_begin, stage_3_done, win, game_over,
               play_enable, current_stage, draw_resetn, draw_timeout
    );
endinterface

// File: rtl/hold_timer.sv
// rtl/hold_timer.sv - loadable down-counter that parks at zero and flags expiry
// Ports: clk, resetn (async active-low), i_load / i_load_val (load wins over counting), o_expired (count is zero)
module hold_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_expired
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_expired = (r_cnt == '0);
endmodule

// File: rtl/game_flow_controller.sv
// rtl/game_flow_controller.sv - top-level game sequencer issuing one-hot screen requests with hold time and draw watchdog
// Ports: clk, resetn (async active-low), bus (game_flow_controller_if.master: inputs start_key, stage_clear,
//        player_dead, *_done; registered outputs screen requests, play_enable, current_stage, draw_resetn, draw_timeout)
module game_flow_controller
    import game_pkg::*;
#(
    parameter int HOLD_CYCLES    = 50_000_000,
    parameter int TIMEOUT_CYCLES = 200_000
) (
    input  logic                  clk,
    input  logic                  resetn,
    game_flow_controller_if.master bus
);
    localparam int CNT_W = cnt_w(HOLD_CYCLES, TIMEOUT_CYCLES);

    state_t       r_state;
    logic [1:0]   r_stage;
    logic         r_armed;
    logic         r_timeout;
    logic         r_wait_start;
    logic [2:0]   r_begin;
    logic [2:0]   r_done;
    logic         r_win;
    logic         r_over;
    logic         r_play;
    logic         r_draw_resetn;

    state_t       w_nxt;
    logic [1:0]   w_nstage;
    logic         w_to_set;
    logic         w_expired;
    logic         w_fire;
    logic         w_begin_done;
    logic         w_end_done;
    logic         w_load;
    logic [CNT_W-1:0] w_load_val;

    // The counter resets to zero, so the first cycle out of reset must load the
    // title watchdog instead of treating zero as an expiry.
    assign w_fire = w_expired & r_armed;

    always_comb begin
        w_begin_done = 1'b0;
        w_end_done   = 1'b0;
        case (r_stage)
            2'd1: begin
                w_begin_done = bus.stage_1_begin_done;
                w_end_done   = bus.stage_1_end_display_done;
            end
            2'd2: begin
                w_begin_done = bus.stage_2_begin_done;
                w_end_done   = bus.stage_2_end_display_done;
            end
            2'd3: begin
                w_begin_done = bus.stage_3_begin_done;
                w_end_done   = bus.stage_3_end_display_done;
            end
            default: ;
        endcase
    end

    // Next state; a done arriving with the watchdog expiry counts as done.
    always_comb begin
        w_nxt    = r_state;
        w_nstage = r_stage;
        w_to_set = 1'b0;
        case (r_state)
            TITLE_DRAW: if (bus.SAVE_GPA_done || w_fire) begin
                w_nxt    = TITLE_WAIT;
                w_to_set = !bus.SAVE_GPA_done;
            end
            TITLE_WAIT: if (bus.start_key) begin
                w_nxt    = BEGIN_DRAW;
                w_nstage = 2'd1;
            end
            BEGIN_DRAW: if (w_begin_done || w_fire) begin
                w_nxt    = BEGIN_HOLD;
                w_to_set = !w_begin_done;
            end
            BEGIN_HOLD: if (w_expired) w_nxt = PLAY;
            PLAY: begin
                if (bus.player_dead)      w_nxt = LOSE_DRAW;
                else if (bus.stage_clear) w_nxt = CLEAR_DRAW;
            end
            CLEAR_DRAW: if (w_end_done || w_fire) begin
                w_nxt    = CLEAR_HOLD;
                w_to_set = !w_end_done;
            end
            CLEAR_HOLD: if (w_expired) begin
                if (r_stage == STAGE_LAST) begin
                    w_nxt = WIN_DRAW;
                end else begin
                    w_nxt    = BEGIN_DRAW;
                    w_nstage = r_stage + 2'd1;
                end
            end
            WIN_DRAW: if (bus.WIN_done || w_fire) begin
                w_nxt    = END_WAIT;
                w_to_set = !bus.WIN_done;
            end
            LOSE_DRAW: if (bus.LOSE_done || w_fire) begin
                w_nxt    = END_WAIT;
                w_to_set = !bus.LOSE_done;
            end
            END_WAIT: if (bus.start_key) begin
                w_nxt    = REARM;
                w_nstage = 2'd0;
            end
            REARM:   w_nxt = TITLE_DRAW;
            default: w_nxt = TITLE_DRAW;
        endcase
    end

    assign w_load     = !r_armed || ((w_nxt != r_state) && (is_draw(w_nxt) || is_hold(w_nxt)));
    assign w_load_val = is_hold(w_nxt) ? CNT_W'(HOLD_CYCLES - 1) : CNT_W'(TIMEOUT_CYCLES - 1);

    hold_timer #(.W(CNT_W)) u_timer (
        .clk        (clk),
        .resetn     (resetn),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_expired  (w_expired)
    );

    // Outputs are decoded from the next state so they move on the same edge as the state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= TITLE_DRAW;
            r_stage       <= 2'd0;
            r_armed       <= 1'b0;
            r_timeout     <= 1'b0;
            r_wait_start  <= 1'b1;
            r_begin       <= 3'b000;
            r_done        <= 3'b000;
            r_win         <= 1'b0;
            r_over        <= 1'b0;
            r_play        <= 1'b0;
            r_draw_resetn <= 1'b1;
        end else begin
            r_state       <= w_nxt;
            r_stage       <= w_nstage;
            r_armed       <= 1'b1;
            if (w_to_set) r_timeout <= 1'b1;
            r_wait_start  <= (w_nxt == TITLE_DRAW) || (w_nxt == TITLE_WAIT);
            r_begin       <= ((w_nxt == BEGIN_DRAW) || (w_nxt == BEGIN_HOLD)) ? stage_onehot(w_nstage) : 3'b000;
            r_done        <= ((w_nxt == CLEAR_DRAW) || (w_nxt == CLEAR_HOLD)) ? stage_onehot(w_nstage) : 3'b000;
            // END_WAIT keeps whichever terminal screen was being drawn.
            r_win         <= (w_nxt == WIN_DRAW)  || ((w_nxt == END_WAIT) && r_win);
            r_over        <= (w_nxt == LOSE_DRAW) || ((w_nxt == END_WAIT) && r_over);
            r_play        <= (w_nxt == PLAY);
            r_draw_resetn <= (w_nxt != REARM);
        end
    end

    assign bus.wait_start    = r_wait_start;
    assign bus.stage_1_begin = r_begin[0];
    assign bus.stage_2_begin = r_begin[1];
    assign bus.stage_3_begin = r_begin[2];
    assign bus.stage_1_done  = r_done[0];
    assign bus.stage_2_done  = r_done[1];
    assign bus.stage_3_done  = r_done[2];
    assign bus.win           = r_win;
    assign bus.game_over     = r_over;
    assign bus.play_enable   = r_play;
    assign bus.current_stage = r_stage;
    assign bus.draw_resetn   = r_draw_resetn;
    assign bus.draw_timeout  = r_timeout;
endmodule

// File: doc/game_flow_controller.md
Name: game_flow_controller

Overview:
- Top-level game sequencer and initiator of the display-request protocol that middle_states answers.
- Drives the one-hot screen requests (wait_start, stage_N_begin, stage_N_done, win, game_over) and consumes the matching *_done handshakes.
- Gates gameplay through play_enable.
- Enforces a visible hold time after each screen finishes drawing, plus a watchdog on every draw.

Parameters:
HOLD_CYCLES, 50_000_000, cycles a finished screen stays selected before advancing (1 s at 50 MHz)
TIMEOUT_CYCLES, 200_000, maximum cycles to wait for a draw *_done before forcing advance

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
start_key  input  1  synchronized one-cycle start/restart pulse
stage_clear  input  1  gameplay reports current stage cleared (pulse)
player_dead  input  1  gameplay reports GPA depleted (pulse)
SAVE_GPA_done  input  1  title screen drawn
stage_1_begin_done, stage_2_begin_done, stage_3_begin_done  input  1 each  stage-start screen drawn
stage_1_end_display_done, stage_2_end_display_done, stage_3_end_display_done  input  1 each  stage-clear screen drawn
WIN_done, LOSE_done  input  1 each  terminal screen drawn
wait_start, stage_1_begin, stage_1_done, stage_2_begin, stage_2_done, stage_3_begin, stage_3_done, win, game_over  output  1 each  registered screen requests, at most one high
play_enable  output  1  gameplay logic may run
current_stage  output  2  1..3 during a game, 0 otherwise
draw_resetn  output  1  active-low pulse that re-arms the draw modules' done flags
draw_timeout  output  1  sticky flag, set when the watchdog fires

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low on resetn.
- Reset values: state=TITLE_DRAW, wait_start=1, all other requests=0, play_enable=0, current_stage=0, draw_resetn=1, draw_timeout=0, counter=0.
- Output registration: all outputs are registered, decoded from next-state, and change on the same edge as the state.
- States and transitions:
  - TITLE_DRAW (wait_start=1): on SAVE_GPA_done or watchdog -> TITLE_WAIT.
  - TITLE_WAIT (wait_start=1): on start_key -> BEGIN_DRAW, stage=1.
  - BEGIN_DRAW (stage_n_begin=1): on stage_n_begin_done or watchdog -> BEGIN_HOLD.
  - BEGIN_HOLD (request still high): after HOLD_CYCLES -> PLAY.
  - PLAY (all requests 0, play_enable=1): player_dead -> LOSE_DRAW; else stage_clear -> CLEAR_DRAW.
  - CLEAR_DRAW (stage_n_done=1): on stage_n_end_display_done or watchdog -> CLEAR_HOLD.
  - CLEAR_HOLD: after HOLD_CYCLES, stage<3 -> BEGIN_DRAW with stage+1; stage=3 -> WIN_DRAW.
  - WIN_DRAW / LOSE_DRAW (win / game_over=1): on WIN_done / LOSE_done or watchdog -> END_WAIT, request held high.
  - END_WAIT: on start_key -> REARM.
  - REARM: draw_resetn=0 for exactly 1 cycle, all requests 0, stage=0 -> TITLE_DRAW.
- Counter:
  - Single shared down-counter, width clog2(max(HOLD_CYCLES,TIMEOUT_CYCLES)+1).
  - Loaded on entry to every *_DRAW (TIMEOUT_CYCLES-1) and *_HOLD (HOLD_CYCLES-1) state.
  - Decrements each cycle; expiry is counter==0 and never wraps.
  - Hold lasts exactly HOLD_CYCLES cycles.
- Watchdog: expiry in a *_DRAW state sets draw_timeout, which stays set until resetn. The advance is identical to receiving done.
- Done handshake:
  - Only the done matching the active request is honoured.
  - Done signals outside their DRAW state, or for another screen, are ignored.
  - Done and watchdog expiry in the same cycle count as done; draw_timeout is not set.
- Simultaneous player_dead and stage_clear in PLAY: player_dead wins. Both inputs are ignored outside PLAY.
- start_key is ignored except in TITLE_WAIT and END_WAIT.
- Reset mid-operation returns to reset values immediately, whatever the state.
- Invariant: exactly one request is high in every state except PLAY and REARM, where none is.

Decomposition:
- Shared package game_pkg:
  - state enum localparams (TITLE_DRAW..REARM)
  - STAGE_LAST=3
  - CNT_W function
- Sub-module hold_timer: loadable down-counter with expired flag. Reused for both the hold and the watchdog because the two never overlap.

Test Plan:
All scenarios use HOLD_CYCLES=4 and TIMEOUT_CYCLES=20.
1. Reset -> wait_start=1. SAVE_GPA_done at cycle 3, start_key at cycle 6 -> stage_1_begin rises on the next edge and current_stage=1.
2. stage_1_begin_done -> stage_1_begin stays high exactly 4 cycles, then play_enable=1 and all requests are 0.
3. Full run: clear stages 1-3 with prompt dones -> win=1 after the stage_3_done hold. start_key -> one draw_resetn=0 cycle, then wait_start=1 and current_stage=0.
4. In PLAY, assert player_dead and stage_clear in the same cycle -> game_over=1 and stage_N_done stays 0.
5. Withhold stage_2_begin_done -> after 20 cycles draw_timeout=1 and the hold starts. draw_timeout stays 1 after a later normal game.
6. Assert stage_3_begin_done while in stage 1 BEGIN_DRAW -> no advance. Assert resetn=0 mid-hold -> all outputs reach reset values before the next clk edge.
